mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch)
//   and the MEM stage (load/store) of the 5-stage pipeline. Accepts one transaction at a time.
//   Data requests win by default, with a starvation guard for fetch.
//   stall_o freezes PC and pipeline registers while any request is waiting for its ack.
// PARAMETERS
//   ADDR_W       32  address width
//   DATA_W       32  data width
//   MEM_LAT      4   memory read latency in cycles (>=1) from the mem_en_o cycle to valid mem_rdata_i
//   IF_MAX_WAIT  8   consecutive arbitration losses by IF before IF is forced to win (>=1)
// PORTS
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       reset, asynchronous, active-high
//   if_req_i     in   1       fetch request, held until if_ack_o
//   if_addr_i    in   ADDR_W  fetch address
//   if_rdata_o   out  DATA_W  fetched instruction, valid while if_ack_o=1
//   if_ack_o     out  1       1-cycle completion pulse for IF
//   dm_req_i     in   1       data request, held until dm_ack_o
//   dm_we_i      in   1       1=store, 0=load
//   dm_addr_i    in   ADDR_W  data address
//   dm_wdata_i   in   DATA_W  store data
//   dm_rdata_o   out  DATA_W  load data, valid while dm_ack_o=1
//   dm_ack_o     out  1       1-cycle completion pulse for DM
//   mem_en_o     out  1       1-cycle access strobe to memory
//   mem_we_o     out  1       write enable, qualified by mem_en_o
//   mem_addr_o   out  ADDR_W  access address, qualified by mem_en_o
//   mem_wdata_o  out  DATA_W  write data, qualified by mem_en_o
//   mem_rdata_i  in   DATA_W  read data, valid MEM_LAT cycles after mem_en_o
//   stall_o      out  1       (if_req_i&~if_ack_o)|(dm_req_i&~dm_ack_o); combinational
// BEHAVIOUR
//   Reset values: all outputs 0, including both rdata registers. FSM=IDLE, counters=0.
//   Reset asserted mid-transaction aborts the access. No ack is issued; requesters reissue.
//   FSM states and transitions:
//   - IDLE:  pick a winner. Latch owner, we, addr and wdata (IF: we=0). Go to ISSUE.
//            No request: stay in IDLE.
//   - ISSUE: one cycle. mem_en_o=1; mem_* driven from latched values. Load cnt=MEM_LAT-1. Go to WAIT.
//   - WAIT:  while cnt!=0, decrement. When cnt==0, capture mem_rdata_i into the owner's rdata
//            register (loads and fetches only; stores leave it unchanged). Go to RESP.
//   - RESP:  owner's ack=1 for exactly one cycle. Go to IDLE.
//   Latency: request first seen in IDLE at cycle 0 -> mem_en_o at cycle 1 -> ack at cycle MEM_LAT+2.
//     No back-to-back overlap; the next arbitration happens in IDLE after RESP.
//   Arbitration (IDLE only):
//   - Only one requesting: it wins.
//   - Both requesting: DM wins, unless starve_cnt==IF_MAX_WAIT, in which case IF wins.
//   - starve_cnt increments, saturating at IF_MAX_WAIT, each time IF requests and loses.
//   - starve_cnt clears when IF is granted or when if_req_i=0 in IDLE.
//   Request dropped before ack: the transaction still completes and the ack still pulses.
//     A store is still performed.
//   A request still high in the cycle after its ack is treated as a new request.
//   Requester inputs are sampled only in IDLE. Changes after the grant are ignored.
//   rdata outputs hold their last captured value between acks.
//   Addresses pass through unmodified. Alignment is the requester's responsibility.
//   mem_we_o, mem_addr_o and mem_wdata_o are 0 whenever mem_en_o=0.
// TESTING
//   1. MEM_LAT=4; if_req at cycle 0, addr 0x10, mem returns 0x00500093
//      -> mem_en_o at cycle 1; if_ack_o at cycle 6 with if_rdata_o=0x00500093; stall_o=1 for cycles 0-5.
//   2. dm_req with we=1, addr 0x20, wdata 0xDEADBEEF -> one mem_en_o with we=1 and matching addr/data;
//      dm_ack_o pulses once; dm_rdata_o unchanged.
//   3. if_req and dm_req both high at cycle 0 -> DM served first, ack at cycle 6;
//      IF mem_en_o at cycle 8; if_ack_o at cycle 13.
//   4. IF_MAX_WAIT=2; dm_req held high continuously while IF also requests
//      -> DM is served twice, then IF is granted on the 3rd arbitration; starve_cnt returns to 0.
//   5. Assert rst_i during WAIT of a DM load -> outputs 0 immediately; no ack; FSM in IDLE;
//      a request reissued after reset completes normally.
//   6. MEM_LAT=1 -> ack exactly 3 cycles after the request is first seen; data captured from the
//      cycle after mem_en_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch (IF)
// and load/store (DM). One transaction is in flight at a time. DM wins ties
// unless IF has lost IF_MAX_WAIT arbitrations in a row. stall_o holds the
// pipeline while either requester is still waiting for its ack.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 4,
  parameter int IF_MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  // Counter only ever holds MEM_LAT-1 down to 0.
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  // Starvation counter saturates at IF_MAX_WAIT.
  localparam int STV_W = $clog2(IF_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(IF_MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner_dm;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [STV_W-1:0]    r_starve;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic                w_starved;
  logic                w_if_wins;
  logic                w_dm_wins;
  logic                w_any_req;
  logic                w_grant;

  // Arbitration: DM by default, IF when alone or once it has been starved.
  assign w_starved = (r_starve == STV_MAX);
  assign w_if_wins = if_req_i & (~dm_req_i | w_starved);
  assign w_dm_wins = dm_req_i & ~w_if_wins;
  assign w_any_req = if_req_i | dm_req_i;
  assign w_grant   = (r_state == S_IDLE) & w_any_req;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; memory bus is forced to zero outside ISSUE.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if_ack_o    = 1'b0;
    dm_ack_o    = 1'b0;
    case (r_state)
      S_ISSUE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = r_we;
        mem_addr_o  = r_addr;
        mem_wdata_o = r_wdata;
      end
      S_RESP: begin
        if_ack_o = ~r_owner_dm;
        dm_ack_o = r_owner_dm;
      end
      default: ;
    endcase
  end

  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  // Latch the winner's transaction at grant; later requester changes are ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_grant) begin
      r_owner_dm <= w_dm_wins;
      r_we       <= w_dm_wins & dm_we_i;
      r_addr     <= w_dm_wins ? dm_addr_i : if_addr_i;
      r_wdata    <= w_dm_wins ? dm_wdata_i : '0;
    end
  end

  // Latency counter: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= CNT_INIT;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Starvation counter: counts consecutive IF losses, cleared on IF grant or idle IF.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE) begin
      if (!if_req_i || w_if_wins) r_starve <= '0;
      else if (!w_starved)        r_starve <= r_starve + STV_W'(1);
    end
  end

  // Capture read data into the owner's register on the last WAIT cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if ((r_state == S_WAIT) && (r_cnt == '0) && !r_we) begin
      if (r_owner_dm) r_dm_rdata <= mem_rdata_i;
      else            r_if_rdata <= mem_rdata_i;
    end
  end

  assign if_rdata_o = r_if_rdata;
  assign dm_rdata_o = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=4/IF_MAX_WAIT=2 and
// MEM_LAT=1/IF_MAX_WAIT=1) share requester inputs; one is checked at a time
// against a transaction-level model, with a memory model answering mem_en_o.
module tb_mem_port_arbiter;
  localparam int A_LAT = 4, A_MAXW = 2, B_LAT = 1, B_MAXW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic        a_if_ack, a_dm_ack, a_en, a_we, a_stall;
  logic [31:0] a_if_rd, a_dm_rd, a_addr, a_wdata;
  logic        b_if_ack, b_dm_ack, b_en, b_we, b_stall;
  logic [31:0] b_if_rd, b_dm_rd, b_addr, b_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(A_LAT), .IF_MAX_WAIT(A_MAXW)) u_a (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(a_if_rd), .if_ack_o(a_if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(a_dm_rd), .dm_ack_o(a_dm_ack),
    .mem_en_o(a_en), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .mem_rdata_i(mem_rdata), .stall_o(a_stall));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(B_LAT), .IF_MAX_WAIT(B_MAXW)) u_b (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(b_if_rd), .if_ack_o(b_if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(b_dm_rd), .dm_ack_o(b_dm_ack),
    .mem_en_o(b_en), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .mem_rdata_i(mem_rdata), .stall_o(b_stall));

  int checks = 0;
  int errors = 0;

  // Selected DUT and its parameters
  bit sel;
  int lat, maxw;
  int cyc;

  // Transaction-level model
  bit          m_busy, m_dm, m_we;
  int          m_g, losses;
  logic [31:0] m_addr, m_wdata, m_rdexp, e_if_rd, e_dm_rd;
  bit          last_ifack, last_dmack;

  // Memory model
  logic [31:0] mem [logic [31:0]];
  bit          rd_pend;
  int          rd_due;
  logic [31:0] rd_data;

  // Observed outputs of the selected DUT in the current cycle
  logic        o_en, o_we, o_ifack, o_dmack, o_stall;
  logic [31:0] o_addr, o_wdata, o_ifrd, o_dmrd;

  function automatic logic [31:0] memv(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a ^ 32'hA5C30F1E) * 32'h9E3779B1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check at negedge+1, advance models.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [31:0] da, input logic [31:0] dwd, input bit r);
    bit x_en, x_ifack, x_dmack, x_stall;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
    mem_rdata = (rd_pend && rd_due == cyc) ? rd_data : $urandom;
    #1;
    if (sel) begin
      o_en = b_en; o_we = b_we; o_addr = b_addr; o_wdata = b_wdata;
      o_ifack = b_if_ack; o_dmack = b_dm_ack; o_stall = b_stall; o_ifrd = b_if_rd; o_dmrd = b_dm_rd;
    end else begin
      o_en = a_en; o_we = a_we; o_addr = a_addr; o_wdata = a_wdata;
      o_ifack = a_if_ack; o_dmack = a_dm_ack; o_stall = a_stall; o_ifrd = a_if_rd; o_dmrd = a_dm_rd;
    end
    if (r) begin
      m_busy = 0; losses = 0; e_if_rd = '0; e_dm_rd = '0; rd_pend = 0;
    end
    x_en    = !r && m_busy && (cyc == m_g + 1);
    x_ifack = !r && m_busy && (cyc == m_g + lat + 2) && !m_dm;
    x_dmack = !r && m_busy && (cyc == m_g + lat + 2) && m_dm;
    if ((x_ifack || x_dmack) && !m_we) begin
      if (m_dm) e_dm_rd = m_rdexp;
      else      e_if_rd = m_rdexp;
    end
    x_stall = (ir & ~x_ifack) | (dr & ~x_dmack);
    if (x_en) m_rdexp = memv(m_addr);
    chk("mem_en",    {31'd0, o_en},    {31'd0, x_en});
    chk("mem_we",    {31'd0, o_we},    {31'd0, x_en & m_we});
    chk("mem_addr",  o_addr,           x_en ? m_addr : 32'd0);
    chk("mem_wdata", o_wdata,          x_en ? m_wdata : 32'd0);
    chk("if_ack",    {31'd0, o_ifack}, {31'd0, x_ifack});
    chk("dm_ack",    {31'd0, o_dmack}, {31'd0, x_dmack});
    chk("stall",     {31'd0, o_stall}, {31'd0, x_stall});
    chk("if_rdata",  o_ifrd,           e_if_rd);
    chk("dm_rdata",  o_dmrd,           e_dm_rd);
    last_ifack = x_ifack;
    last_dmack = x_dmack;
    if (!r) begin
      if (m_busy && (cyc == m_g + lat + 2)) begin
        m_busy = 0;
      end else if (!m_busy) begin
        if (ir && (!dr || losses == maxw)) begin
          m_busy = 1; m_g = cyc; m_dm = 0; m_we = 0; m_addr = ia; m_wdata = '0; losses = 0;
        end else if (dr) begin
          m_busy = 1; m_g = cyc; m_dm = 1; m_we = dwe; m_addr = da; m_wdata = dwd;
          losses = ir ? losses + 1 : 0;
        end else begin
          losses = 0;
        end
      end
      if (o_en) begin
        if (o_we) mem[o_addr] = o_wdata;
        else begin rd_pend = 1; rd_due = cyc + lat; rd_data = memv(o_addr); end
      end
    end
    cyc++;
  endtask

  function automatic logic [31:0] raddr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // Random requesters that mostly hold until ack, sometimes drop early or re-request at once.
  task automatic rand_run(input int n);
    bit iact, dact, dwe;
    logic [31:0] ia, da, dwd;
    iact = 0; dact = 0; dwe = 0; ia = '0; da = '0; dwd = '0;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        iact = 0; dact = 0;
        step(0, 0, 0, 0, 0, 0, 1);
        continue;
      end
      if (last_ifack) iact = 0;
      if (last_dmack) dact = 0;
      if (iact) begin
        if ($urandom_range(0, 15) == 0) iact = 0;
        else if ($urandom_range(0, 7) == 0) ia = raddr();
      end else if ($urandom_range(0, 2) == 0) begin
        iact = 1; ia = raddr();
      end
      if (dact) begin
        if ($urandom_range(0, 15) == 0) dact = 0;
        else if ($urandom_range(0, 7) == 0) dwd = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        dact = 1; da = raddr(); dwe = 1'($urandom_range(0, 1)); dwd = $urandom;
      end
      step(iact, ia, dact, dwe, da, dwd, 0);
    end
  endtask

  initial begin
    int en1, en2, ack_i, ack_d, nst, nen, nack, nd, nif, d_first, d_second;
    bit done, ifh, dmh, s_we;
    logic [31:0] rd, s_addr, s_wdata;

    rst = 1; if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    sel = 0; lat = A_LAT; maxw = A_MAXW; cyc = 0;
    m_busy = 0; m_dm = 0; m_we = 0; m_g = 0; losses = 0;
    m_addr = '0; m_wdata = '0; m_rdexp = '0; e_if_rd = '0; e_dm_rd = '0;
    last_ifack = 0; last_dmack = 0; rd_pend = 0; rd_due = 0; rd_data = '0;
    mem[32'h10] = 32'h00500093;
    mem[32'h30] = 32'h12345678;

    // Reset: every output zero
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Single fetch, MEM_LAT=4
    en1 = -1; ack_i = -1; nst = 0; done = 0; rd = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 32'h10, 0, 0, 0, 0, 0);
      if (o_en && en1 < 0) en1 = i;
      if (o_stall) nst++;
      if (o_ifack) begin ack_i = i; rd = o_ifrd; done = 1; end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t1_en_cycle", en1, 1);
    chk("t1_ack_cycle", ack_i, 6);
    chk("t1_rdata", rd, 32'h00500093);
    chk("t1_stall_cycles", nst, 6);

    // DM load to give dm_rdata a known value
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(0, 0, 1, 0, 32'h30, 0, 0);
      if (o_dmack) done = 1;
    end
    chk("t2_load_rdata", o_dmrd, 32'h12345678);

    // DM store
    nen = 0; nack = 0; done = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, !done, 1, 32'h20, 32'hDEADBEEF, 0);
      if (o_en) begin nen++; s_we = o_we; s_addr = o_addr; s_wdata = o_wdata; end
      if (o_dmack) begin nack++; done = 1; end
    end
    chk("t2_en_count", nen, 1);
    chk("t2_we", {31'd0, s_we}, 1);
    chk("t2_addr", s_addr, 32'h20);
    chk("t2_wdata", s_wdata, 32'hDEADBEEF);
    chk("t2_ack_count", nack, 1);
    chk("t2_dm_rdata_kept", o_dmrd, 32'h12345678);

    // Simultaneous requests: DM first, then IF
    ifh = 1; dmh = 1; nen = 0; en1 = -1; en2 = -1; ack_i = -1; ack_d = -1;
    for (int i = 0; i < 30 && (ifh || dmh); i++) begin
      step(ifh, 32'h10, dmh, 0, 32'h30, 0, 0);
      if (o_en) begin
        if (nen == 0) en1 = i;
        else if (nen == 1) en2 = i;
        nen++;
      end
      if (o_dmack) begin ack_d = i; dmh = 0; end
      if (o_ifack) begin ack_i = i; ifh = 0; end
    end
    chk("t3_dm_en", en1, 1);
    chk("t3_dm_ack", ack_d, 6);
    chk("t3_if_en", en2, 8);
    chk("t3_if_ack", ack_i, 13);
    step(0, 0, 0, 0, 0, 0, 0);

    // Starvation guard, IF_MAX_WAIT=2, both held continuously
    nd = 0; nif = 0; d_first = -1; d_second = -1;
    for (int i = 0; i < 100 && nif < 2; i++) begin
      step(1, 32'h10, 1, 0, 32'h30, 0, 0);
      if (o_dmack) nd++;
      if (o_ifack) begin
        nif++;
        if (nif == 1) d_first = nd; else d_second = nd;
        nd = 0;
      end
    end
    chk("t4_dm_before_if", d_first, 2);
    chk("t4_dm_after_if", d_second, 2);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset during WAIT of a DM load
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h30, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t5_rst_dm_rdata", o_dmrd, 0);
    chk("t5_rst_mem_en", {31'd0, o_en}, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      if (o_dmack || o_ifack) nack++;
    end
    chk("t5_no_ack_after_abort", nack, 0);
    ack_d = -1; done = 0; rd = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(0, 0, 1, 0, 32'h30, 0, 0);
      if (o_dmack) begin ack_d = i; rd = o_dmrd; done = 1; end
    end
    chk("t5_reissue_ack", ack_d, 6);
    chk("t5_reissue_rdata", rd, 32'h12345678);
    step(0, 0, 0, 0, 0, 0, 0);

    rand_run(1500);

    // Switch to the MEM_LAT=1, IF_MAX_WAIT=1 instance
    sel = 1; lat = B_LAT; maxw = B_MAXW;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    mem[32'h10] = 32'h00500093;
    en1 = -1; ack_i = -1; done = 0; rd = '0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 32'h10, 0, 0, 0, 0, 0);
      if (o_en && en1 < 0) en1 = i;
      if (o_ifack) begin ack_i = i; rd = o_ifrd; done = 1; end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t6_en_cycle", en1, 1);
    chk("t6_ack_cycle", ack_i, 3);
    chk("t6_rdata", rd, 32'h00500093);

    // IF_MAX_WAIT=1: one DM grant then IF
    nd = 0; d_first = -1; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1, 32'h10, 1, 0, 32'h30, 0, 0);
      if (o_dmack) nd++;
      if (o_ifack) begin d_first = nd; done = 1; end
    end
    chk("t6_dm_before_if", d_first, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    rand_run(800);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
